// File: rtl/four_phase_rx_bridge.sv
// ----------------------------------------------------------------------------
// four_phase_rx_bridge
//
// Purpose:
//   Receives words from an asynchronous four-phase (return-to-zero) request/
//   acknowledge bundle and buffers them in a small FIFO for a synchronous
//   valid/ready consumer. The request is synchronized into the clk domain.
//   Each four-phase cycle produces exactly one FIFO push. When the FIFO is
//   full, the acknowledge is withheld to apply backpressure to the sender.
//
// Optional feature:
//   Define FOUR_PHASE_RX_TIMEOUT_EN to compile in a handshake watchdog. The
//   watchdog sets the sticky err flag when the FSM stays in ACK or DRAIN for
//   TIMEOUT_CYC cycles. Without the macro, err is tied low.
//
// Parameters:
//   DATA_W      - bundled data width
//   DEPTH       - FIFO entries (power of two, 2..16)
//   SYNC_STAGES - req_in synchronizer flops (2..3)
//   TIMEOUT_CYC - watchdog limit in clk cycles (1..65535)
//
// Ports:
//   clk      in   sole clock, rising edge
//   rst      in   synchronous active-high reset
//   req_in   in   four-phase request (asynchronous to clk)
//   data_in  in   bundled data, stable while req_in is high
//   ack_out  out  four-phase acknowledge (registered)
//   m_valid  out  FIFO head valid
//   m_data   out  FIFO head word
//   m_ready  in   downstream accepts head when m_valid is high
//   level    out  FIFO occupancy
//   err      out  sticky handshake timeout flag
// ----------------------------------------------------------------------------
module four_phase_rx_bridge #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_in,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     ack_out,
    output logic                     m_valid,
    output logic [DATA_W-1:0]        m_data,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        DRAIN = 2'd0,
        IDLE  = 2'd1,
        ACK   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Request synchronizer
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    // r_sync_vld marks how many synchronizer stages hold a real sample of
    // req_in since reset. Reset clears the flops to 0, so req_s would falsely
    // read low for a few cycles after reset. DRAIN must ignore that false low.
    // Otherwise, a request still held high across reset would be captured
    // again.
    logic [SYNC_STAGES-1:0] r_sync_vld;
    logic                   w_req_s;
    logic                   w_sync_primed;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values of its neighbours; blocking here would turn the
    // synchronizer chain into a single wire.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= '0;
            r_sync_vld <= '0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], req_in};
            r_sync_vld <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_req_s       = r_sync[SYNC_STAGES-1];
    assign w_sync_primed = r_sync_vld[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              w_full;
    logic              w_pop;
    logic              w_push;

    // Push eligibility uses the pre-edge level. A pop on the same edge that
    // the FIFO is full therefore cannot enable a push until the next cycle.
    assign w_full = (r_level == LVL_W'(DEPTH));
    assign w_pop  = (r_level != '0) && m_ready;

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_next_state;
    logic   r_ack;

    // NOTE: every signal written here receives a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        case (r_state)
            DRAIN: begin
                if (w_sync_primed && !w_req_s) begin
                    w_next_state = IDLE;
                end
            end
            IDLE: begin
                if (w_req_s && !w_full) begin
                    w_push       = 1'b1;
                    w_next_state = ACK;
                end
            end
            ACK: begin
                if (!w_req_s) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = DRAIN;
            end
        endcase
    end

    // The acknowledge flop is loaded with the decoded next state. It is
    // therefore a true register, and it is aligned exactly with the state
    // register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DRAIN;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ack   <= (w_next_state == ACK);
        end
    end

    assign ack_out = r_ack;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: the storage array has no reset; the pointers and level define
    // which entries are meaningful, so clearing the data would only cost
    // reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    assign level   = r_level;
    assign m_valid = (r_level != '0);
    assign m_data  = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // Handshake watchdog
    // ------------------------------------------------------------------
`ifdef FOUR_PHASE_RX_TIMEOUT_EN
    localparam int CNT_W = 16;

    logic [CNT_W-1:0] r_wd_cnt;
    logic [CNT_W-1:0] w_wd_cnt_next;
    logic             r_err;

    // The counter restarts on every state change. It advances only while
    // the FSM waits in ACK or DRAIN, and it saturates at the limit.
    always_comb begin
        w_wd_cnt_next = r_wd_cnt;
        if (w_next_state != r_state) begin
            w_wd_cnt_next = '0;
        end else if ((r_state != IDLE) && (r_wd_cnt != CNT_W'(TIMEOUT_CYC))) begin
            w_wd_cnt_next = r_wd_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_wd_cnt <= w_wd_cnt_next;
            if (w_wd_cnt_next == CNT_W'(TIMEOUT_CYC)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
